// File: rtl/dkong_col_mix.sv
// Final colour stage: background/sprite priority mux, palette lookup RAM,
// and blanked 3-3-2 RGB output. Three pixel-strobe stages give a fixed
// two-strobe latency from pixel inputs to O_R/O_G/O_B/O_BLANK.
module dkong_col_mix (
    input  logic       CLK_12M,
    input  logic       I_RST,
    input  logic       I_PIX_CE,
    input  logic [1:0] I_BG_VID,
    input  logic [3:0] I_BG_COL,
    input  logic [1:0] I_OBJ_VID,
    input  logic [3:0] I_OBJ_COL,
    input  logic       I_CMPBLK,
    input  logic       I_AB,
    input  logic       I_DB,
    input  logic       I_BANK_WRn,
    input  logic       I_CNF_EN,
    input  logic [7:0] I_CNF_A,
    input  logic [7:0] I_CNF_D,
    input  logic       I_CNF_WE,
    output logic [2:0] O_R,
    output logic [2:0] O_G,
    output logic [1:0] O_B,
    output logic       O_BLANK
);

    // The palette RAM holds the PROM image verbatim, which is active-low;
    // the displayed colour is its complement.
    function automatic logic [7:0] prom_decode(input logic [7:0] prom);
        return ~prom;
    endfunction

    logic [1:0] bank;
    logic [7:0] pix_addr;
    logic [7:0] addr_p1;
    logic       blk_p1;
    logic [7:0] clut [0:255];
    logic [7:0] rd_data_p1;
    logic [7:0] data_p2;
    logic       blk_p2;

    // Palette bank latch, written bit-wise by the CPU.
    always_ff @(posedge CLK_12M) begin
        if (I_RST) begin
            bank <= 2'b00;
        end else if (!I_BANK_WRn) begin
            bank[I_AB] <= I_DB;
        end
    end

    // Sprite has priority whenever its pixel index is non-transparent.
    always_comb begin
        pix_addr = {bank, I_BG_COL, I_BG_VID};
        if (I_OBJ_VID != 2'd0) begin
            pix_addr = {bank, I_OBJ_COL, I_OBJ_VID};
        end
    end

    // ---- stage 1: priority mux result and blank, captured per pixel ----
    always_ff @(posedge CLK_12M) begin
        if (I_RST) begin
            addr_p1 <= 8'd0;
            blk_p1  <= 1'b1;
        end else if (I_PIX_CE) begin
            addr_p1 <= pix_addr;
            blk_p1  <= I_CMPBLK | I_CNF_EN;
        end
    end

    // Lookup RAM: config writes plus a free-running read (old data on collision).
    always_ff @(posedge CLK_12M) begin
        if (I_CNF_EN && I_CNF_WE) begin
            clut[I_CNF_A] <= I_CNF_D;
        end
        rd_data_p1 <= clut[addr_p1];
    end

    // ---- stage 2: looked-up colour held for one pixel ----
    always_ff @(posedge CLK_12M) begin
        if (I_PIX_CE) begin
            data_p2 <= rd_data_p1;
        end
    end

    // Stage 2 blank travels alongside the looked-up colour.
    always_ff @(posedge CLK_12M) begin
        if (I_RST) begin
            blk_p2 <= 1'b1;
        end else if (I_PIX_CE) begin
            blk_p2 <= blk_p1;
        end
    end

    // ---- stage 3: blanked RGB output, config mode forces black at once ----
    always_ff @(posedge CLK_12M) begin
        if (I_RST) begin
            O_R     <= 3'd0;
            O_G     <= 3'd0;
            O_B     <= 2'd0;
            O_BLANK <= 1'b1;
        end else if (I_PIX_CE) begin
            if (blk_p2 || I_CNF_EN) begin
                O_R     <= 3'd0;
                O_G     <= 3'd0;
                O_B     <= 2'd0;
                O_BLANK <= 1'b1;
            end else begin
                {O_R, O_G, O_B} <= prom_decode(data_p2);
                O_BLANK         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dkong_col_mix.sv
// Bench for dkong_col_mix: strobe-level reference model checked every cycle,
// plus directed scenarios with hand-computed colours.
module tb_dkong_col_mix;

    logic       CLK_12M = 1'b0;
    logic       I_RST = 1'b1;
    logic       I_PIX_CE = 1'b0;
    logic [1:0] I_BG_VID = '0;
    logic [3:0] I_BG_COL = '0;
    logic [1:0] I_OBJ_VID = '0;
    logic [3:0] I_OBJ_COL = '0;
    logic       I_CMPBLK = 1'b1;
    logic       I_AB = 1'b0;
    logic       I_DB = 1'b0;
    logic       I_BANK_WRn = 1'b1;
    logic       I_CNF_EN = 1'b0;
    logic [7:0] I_CNF_A = '0;
    logic [7:0] I_CNF_D = '0;
    logic       I_CNF_WE = 1'b0;
    logic [2:0] O_R;
    logic [2:0] O_G;
    logic [1:0] O_B;
    logic       O_BLANK;

    always #5 CLK_12M = ~CLK_12M;

    dkong_col_mix dut (
        .CLK_12M(CLK_12M), .I_RST(I_RST), .I_PIX_CE(I_PIX_CE),
        .I_BG_VID(I_BG_VID), .I_BG_COL(I_BG_COL),
        .I_OBJ_VID(I_OBJ_VID), .I_OBJ_COL(I_OBJ_COL),
        .I_CMPBLK(I_CMPBLK), .I_AB(I_AB), .I_DB(I_DB), .I_BANK_WRn(I_BANK_WRn),
        .I_CNF_EN(I_CNF_EN), .I_CNF_A(I_CNF_A), .I_CNF_D(I_CNF_D), .I_CNF_WE(I_CNF_WE),
        .O_R(O_R), .O_G(O_G), .O_B(O_B), .O_BLANK(O_BLANK)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: palette copy, bank, two in-flight pixels, output.
    logic [7:0] mram [256];
    logic [1:0] mbank = 2'b00;
    logic       mblk [2];
    logic [7:0] mrgb [2];
    logic [7:0] mout = 8'd0;
    logic       mblank = 1'b1;

    bit         phase = 1'b1;
    logic [8:0] prev_out;
    bit         wr_strobe = 0, wr_idle = 0;
    logic       wr_ab = 0, wr_db = 0;

    task automatic model_clk();
        logic [7:0] a;
        if (I_RST) begin
            mbank = 2'b00;
            mblk[0] = 1'b1; mblk[1] = 1'b1;
            mout = 8'd0; mblank = 1'b1;
        end else begin
            if (I_PIX_CE) begin
                if (mblk[1] || I_CNF_EN) begin
                    mout = 8'd0; mblank = 1'b1;
                end else begin
                    mout = mrgb[1]; mblank = 1'b0;
                end
                mblk[1] = mblk[0];
                mrgb[1] = mrgb[0];
                a = (I_OBJ_VID != 2'd0) ? {mbank, I_OBJ_COL, I_OBJ_VID}
                                        : {mbank, I_BG_COL, I_BG_VID};
                mblk[0] = I_CMPBLK | I_CNF_EN;
                mrgb[0] = ~mram[a];
            end
            if (!I_BANK_WRn) mbank[I_AB] = I_DB;
        end
        if (I_CNF_EN && I_CNF_WE) mram[I_CNF_A] = I_CNF_D;
    endtask

    // One CLK_12M cycle; strobe on alternate cycles; compare at the falling edge.
    task automatic cyc();
        I_PIX_CE = phase;
        @(posedge CLK_12M);
        model_clk();
        @(negedge CLK_12M);
        chk("rgb", {O_R, O_G, O_B}, mout);
        chk("blank", O_BLANK, mblank);
        if (!I_PIX_CE && !I_RST) chk("hold", {O_R, O_G, O_B, O_BLANK}, prev_out);
        prev_out = {O_R, O_G, O_B, O_BLANK};
        phase = ~phase;
    endtask

    // One pixel: a strobe cycle followed by an idle cycle.
    task automatic pix(input logic [1:0] bv, input logic [3:0] bc,
                       input logic [1:0] ov, input logic [3:0] oc, input logic blk);
        I_BG_VID = bv; I_BG_COL = bc; I_OBJ_VID = ov; I_OBJ_COL = oc; I_CMPBLK = blk;
        if (!phase) cyc();
        I_AB = wr_ab; I_DB = wr_db;
        I_BANK_WRn = ~wr_strobe;
        cyc();
        I_BANK_WRn = ~wr_idle;
        cyc();
        I_BANK_WRn = 1'b1;
        wr_strobe = 0; wr_idle = 0;
    endtask

    task automatic set_bank(input logic [1:0] b);
        wr_idle = 1; wr_ab = 1'b1; wr_db = b[1];
        pix(2'd0, 4'd0, 2'd0, 4'd0, 1'b1);
        wr_idle = 1; wr_ab = 1'b0; wr_db = b[0];
        pix(2'd0, 4'd0, 2'd0, 4'd0, 1'b1);
    endtask

    task automatic rand_inputs();
        I_BG_VID = 2'($urandom); I_BG_COL = 4'($urandom);
        I_OBJ_VID = 2'($urandom); I_OBJ_COL = 4'($urandom);
        I_CMPBLK = 1'($urandom);
    endtask

    function automatic logic [7:0] fixed_val(input logic [7:0] a, input logic [7:0] dflt);
        case (a)
            8'h05: return 8'h00;
            8'h0E: return 8'hFF;
            8'h3E: return 8'h1C;
            8'hC1: return 8'hE3;
            8'hC5: return 8'hFF;
            8'h45: return 8'h5A;
            default: return dflt;
        endcase
    endfunction

    initial begin
        logic [7:0] fixed_addrs [6];
        fixed_addrs = '{8'h05, 8'h0E, 8'h3E, 8'hC1, 8'hC5, 8'h45};
        mblk[0] = 1'b1; mblk[1] = 1'b1;
        mrgb[0] = 8'd0; mrgb[1] = 8'd0;

        // Reset with random inputs
        I_RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            cyc();
            chk("rst_state", {O_R, O_G, O_B, O_BLANK}, 9'b000_000_00_1);
        end
        I_RST = 1'b0;

        // Load the whole palette in config mode; output must stay black
        I_CNF_EN = 1'b1;
        for (int a = 0; a < 256; a++) begin
            rand_inputs();
            I_CMPBLK = 1'b0;
            I_CNF_A = 8'(a);
            I_CNF_D = fixed_val(8'(a), 8'($urandom));
            I_CNF_WE = 1'b1;
            cyc();
            chk("cnf_black", {O_R, O_G, O_B, O_BLANK}, 9'b000_000_00_1);
        end
        I_CNF_WE = 1'b0;
        cyc(); cyc();
        I_CNF_EN = 1'b0;

        // Write strobes without config mode must be ignored
        for (int i = 0; i < 6; i++) begin
            I_CNF_A = fixed_addrs[i];
            I_CNF_D = ~fixed_val(fixed_addrs[i], 8'h00);
            I_CNF_WE = 1'b1;
            pix(2'd0, 4'd0, 2'd0, 4'd0, 1'b1);
        end
        I_CNF_WE = 1'b0;

        // Reset after selecting bank 3: bank must return to 0
        set_bank(2'd3);
        I_RST = 1'b1; I_BANK_WRn = 1'($urandom); I_AB = 1'($urandom); I_DB = 1'($urandom);
        rand_inputs();
        cyc(); cyc();
        I_RST = 1'b0; I_BANK_WRn = 1'b1;
        chk("rst_blank", {O_R, O_G, O_B, O_BLANK}, 9'b000_000_00_1);
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        chk("rst_s1", {O_R, O_G, O_B, O_BLANK}, 9'b000_000_00_1);
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        chk("rst_s2", {O_R, O_G, O_B, O_BLANK}, 9'b000_000_00_1);
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        chk("rst_first", {O_R, O_G, O_B, O_BLANK}, {3'd7, 3'd7, 2'd3, 1'b0});

        // Priority
        for (int i = 0; i < 3; i++) pix(2'd2, 4'd3, 2'd0, 4'd0, 1'b0);
        chk("prio_bg", {O_R, O_G, O_B, O_BLANK}, {3'd0, 3'd0, 2'd0, 1'b0});
        for (int i = 0; i < 3; i++) pix(2'd2, 4'd3, 2'd2, 4'd15, 1'b0);
        chk("prio_obj", {O_R, O_G, O_B, O_BLANK}, {3'd7, 3'd0, 2'd3, 1'b0});

        // Bank latch, then a bank write coinciding with a strobe
        wr_idle = 1; wr_ab = 1'b1; wr_db = 1'b1; pix(2'd1, 4'd0, 2'd0, 4'd0, 1'b0);
        wr_idle = 1; wr_ab = 1'b0; wr_db = 1'b1; pix(2'd1, 4'd0, 2'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) pix(2'd1, 4'd0, 2'd0, 4'd0, 1'b0);
        chk("bank3", {O_R, O_G, O_B, O_BLANK}, {3'd0, 3'd7, 2'd0, 1'b0});
        wr_strobe = 1; wr_ab = 1'b1; wr_db = 1'b0;
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        chk("bank_pre", {O_R, O_G, O_B, O_BLANK}, {3'd0, 3'd7, 2'd0, 1'b0});
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        chk("bank_old", {O_R, O_G, O_B, O_BLANK}, {3'd0, 3'd0, 2'd0, 1'b0});
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        chk("bank_new", {O_R, O_G, O_B, O_BLANK}, {3'd5, 3'd1, 2'd1, 1'b0});

        // Single-pixel blank pulse, two strobes of latency
        set_bank(2'd0);
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b1);
        chk("blk_p0", {O_R, O_G, O_B, O_BLANK}, {3'd7, 3'd7, 2'd3, 1'b0});
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        chk("blk_p1", {O_R, O_G, O_B, O_BLANK}, {3'd7, 3'd7, 2'd3, 1'b0});
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        chk("blk_p2", {O_R, O_G, O_B, O_BLANK}, 9'b000_000_00_1);
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        chk("blk_p3", {O_R, O_G, O_B, O_BLANK}, {3'd7, 3'd7, 2'd3, 1'b0});

        // Entering config mode blacks the very next strobe
        I_CNF_EN = 1'b1;
        pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        chk("cnf_rise", {O_R, O_G, O_B, O_BLANK}, 9'b000_000_00_1);
        I_CNF_EN = 1'b0;
        for (int i = 0; i < 3; i++) pix(2'd1, 4'd1, 2'd0, 4'd0, 1'b0);
        chk("cnf_fall", {O_R, O_G, O_B, O_BLANK}, {3'd7, 3'd7, 2'd3, 1'b0});

        // Read back all 256 palette entries through the background path
        for (int b = 0; b < 4; b++) begin
            set_bank(2'(b));
            for (int k = 0; k < 64; k++) pix(2'(k), 4'(k >> 2), 2'd0, 4'd0, 1'b0);
        end
        pix(2'd0, 4'd0, 2'd0, 4'd0, 1'b1);
        pix(2'd0, 4'd0, 2'd0, 4'd0, 1'b1);

        // Random traffic: pixels, blanking, bank writes, config pulses, resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                wr_strobe = 1'($urandom); wr_idle = ~wr_strobe;
                wr_ab = 1'($urandom); wr_db = 1'($urandom);
            end
            I_CNF_EN = ($urandom_range(0, 29) == 0);
            I_CNF_WE = 1'($urandom) & ~I_CNF_EN;
            I_CNF_A = 8'($urandom); I_CNF_D = 8'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                I_RST = 1'b1; cyc(); I_RST = 1'b0;
            end
            pix(2'($urandom), 4'($urandom), 2'($urandom), 4'($urandom),
                ($urandom_range(0, 7) == 0));
        end
        I_CNF_EN = 1'b0; I_CNF_WE = 1'b0;
        pix(2'd0, 4'd0, 2'd0, 4'd0, 1'b0);
        pix(2'd0, 4'd0, 2'd0, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
